// File: rtl/sd_pkg.sv
// Shared types and constants for the SD receive block packer: FSM states,
// status word layout and the CRC16-CCITT polynomial.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH,
    ST_STATUS,
    ST_DONE
  } pack_state_e;

  localparam int STAT_BYTES_LSB = 32;
  localparam int STAT_CRC_LSB   = 16;
  localparam int STAT_WORDS_LSB = 0;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  function automatic logic [63:0] status_word(input logic [15:0] bytes,
                                              input logic [15:0] crc,
                                              input logic [9:0]  words);
    logic [63:0] w;
    w = '0;
    w[STAT_BYTES_LSB +: 16] = bytes;
    w[STAT_CRC_LSB   +: 16] = crc;
    w[STAT_WORDS_LSB +: 10] = words;
    return w;
  endfunction

endpackage

// File: rtl/sd_rx_block_packer_if.sv
// Byte-stream input and RAM port A write bus of the SD receive block packer.
// master = packer side, slave = receiver/RAM side.
interface sd_rx_block_packer_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       ram_data;
  logic              ram_wr;

  modport master (input rx_byte, rx_valid, output rx_ready, ram_addr, ram_data, ram_wr);
  modport slave  (output rx_byte, rx_valid, input rx_ready, ram_addr, ram_data, ram_wr);
endinterface

// File: rtl/sd_crc16_byte.sv
// Combinational CRC16-CCITT update for one byte, MSB first.
module sd_crc16_byte
  import sd_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] c;

  always_comb begin
    c = crc_i ^ {data_i, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    crc_o = c;
  end
endmodule

// File: rtl/sd_rx_block_packer.sv
// Packs the SD DAT byte stream MSB-first into 64-bit RAM words, then writes a
// status word and pulses done. Define SD_PACK_CRC_EN to include the CRC16 field.
module sd_rx_block_packer
  import sd_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int BASE_ADDR   = 0,
  parameter int STATUS_ADDR = 65,
  parameter int MAX_BYTES   = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [9:0]             blk_len,
  input  logic                   abort,
  sd_rx_block_packer_if.master   bus,
  output logic                   busy,
  output logic                   done
);
  pack_state_e       state_q, state_d;
  logic [9:0]        len_q, len_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [6:0]        word_cnt_q, word_cnt_d;
  logic [63:0]       shift_q, shift_d;
  logic              rx_ready_q, rx_ready_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [63:0]       ram_data_q, ram_data_d;
  logic              ram_wr_q, ram_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       crc_val;

  logic [2:0]        lane;
  logic [63:0]       shift_ins;
  logic              xfer, last_byte;

  assign lane      = byte_cnt_q[2:0];
  assign shift_ins = shift_q | ({56'h0, bus.rx_byte} << {3'd7 - lane, 3'b000});
  assign xfer      = rx_ready_q & bus.rx_valid;
  assign last_byte = (byte_cnt_q + 10'd1) == len_q;

`ifdef SD_PACK_CRC_EN
  logic [15:0] crc_q, crc_d, crc_upd;

  sd_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (bus.rx_byte),
    .crc_o  (crc_upd)
  );

  assign crc_val = crc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= 16'h0;
    else       crc_q <= crc_d;
  end

  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE && start)       crc_d = 16'h0;
    else if (state_q == ST_FILL && xfer)   crc_d = crc_upd;
  end
`else
  assign crc_val = 16'h0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    rx_ready_d = rx_ready_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wr_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = (blk_len == 10'd0) ? 10'(MAX_BYTES) : blk_len;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          shift_d    = '0;
          rx_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          // A full word or the block's final partial word is written straight away.
          if (lane == 3'd7 || last_byte) begin
            ram_wr_d   = 1'b1;
            ram_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
            ram_data_d = shift_ins;
            word_cnt_d = word_cnt_q + 7'd1;
            shift_d    = '0;
          end else begin
            shift_d    = shift_ins;
          end
          if (last_byte) begin
            rx_ready_d = 1'b0;
            state_d    = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = ADDR_W'(STATUS_ADDR);
        ram_data_d = status_word({6'h0, byte_cnt_q}, crc_val, {3'h0, word_cnt_q});
        state_d    = ST_STATUS;
      end
      ST_STATUS: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any transfer or pending write decided this cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      rx_ready_d = 1'b0;
      ram_wr_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      rx_ready_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      rx_ready_q <= rx_ready_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wr_q   <= ram_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_wr   = ram_wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_sd_rx_block_packer.sv
// Scoreboard bench for sd_rx_block_packer: expected RAM writes and done cycles
// are queued at stimulus time and checked by an independent monitor.
module tb_sd_rx_block_packer;
`ifdef SD_PACK_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [9:0] blk_len;
  logic       busy, done;

  sd_rx_block_packer_if bus ();

  sd_rx_block_packer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .blk_len (blk_len),
    .abort   (abort),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  int         exp_done[$];
  wr_t        mon_e;
  int         mon_c;
  logic [7:0] blk [512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int len);
    logic [15:0] c;
    c = 16'h0;
    for (int i = 0; i < len; i++) begin
      c = c ^ {blk[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (bus.ram_wr === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.ram_addr, bus.ram_data);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", 64'(bus.ram_addr), 64'(mon_e.addr));
        check("wr_data", bus.ram_data, mon_e.data);
      end
    end
    if (done === 1'b1) begin
      check("busy_in_done", 64'(busy), 64'd1);
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
      end else begin
        mon_c = exp_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  task automatic push_words(input int len, input int nwords);
    wr_t e;
    for (int w = 0; w < nwords; w++) begin
      e.addr = 7'(w);
      e.data = 64'h0;
      for (int k = 0; k < 8; k++)
        if (8 * w + k < len) e.data[63 - 8 * k -: 8] = blk[8 * w + k];
      exp_wr.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  // mode 0: complete block, 1: abort after stop_after bytes, 2: reset after stop_after bytes
  task automatic run_block(input int len, input bit throttle, input int mode,
                           input int stop_after, input logic [15:0] crc_exp);
    int  nw, n, acc;
    wr_t e;
    nw = (len + 7) / 8;
    n  = (mode == 0) ? len : stop_after;
    if (mode == 0) begin
      push_words(len, nw);
      e.addr = 7'd65;
      e.data = {16'h0, 16'(len), crc_exp, 16'(nw)};
      exp_wr.push_back(e);
    end else begin
      push_words(len, stop_after / 8);
    end

    @(posedge clk); #1;
    start   = 1'b1;
    blk_len = 10'(len);
    @(posedge clk); #1;
    start   = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);

    for (int i = 0; i < n; i++) begin
      send_byte(blk[i], acc);
      if (mode == 0 && i == n - 1) exp_done.push_back(acc + 3);
      if (throttle) begin
        @(posedge clk); #1;
      end
    end

    if (mode == 1) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("busy_after_abort", 64'(busy), 64'd0);
      check("ready_after_abort", 64'(bus.rx_ready), 64'd0);
    end else if (mode == 2) begin
      #2 reset = 1'b1;
      #1;
      check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
      check("rst_ram_wr", 64'(bus.ram_wr), 64'd0);
      check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
      check("rst_ram_data", bus.ram_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
    end

    repeat (8) @(posedge clk);
    #1;
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    exp_wr.delete();
    exp_done.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    blk_len      = 10'd0;
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("reset_ram_wr", 64'(bus.ram_wr), 64'd0);
    check("reset_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("reset_ram_data", bus.ram_data, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Full 512-byte block
    for (int i = 0; i < 512; i++) blk[i] = 8'(i);
    run_block(512, 1'b0, 0, 0, CRC_ON ? crc_model(512) : 16'h0);

    // 13-byte block ending in a partial word
    for (int i = 0; i < 13; i++) blk[i] = 8'hA0 + 8'(i);
    run_block(13, 1'b0, 0, 0, CRC_ON ? crc_model(13) : 16'h0);

    // Throttled input
    for (int i = 0; i < 16; i++) blk[i] = 8'h40 + 8'(3 * i);
    run_block(16, 1'b1, 0, 0, CRC_ON ? crc_model(16) : 16'h0);

    // Abort after 20 bytes, then a clean block
    for (int i = 0; i < 512; i++) blk[i] = 8'(i);
    run_block(512, 1'b0, 1, 20, 16'h0);
    for (int i = 0; i < 24; i++) blk[i] = 8'hC0 ^ 8'(i);
    run_block(24, 1'b0, 0, 0, CRC_ON ? crc_model(24) : 16'h0);

    // Standard CRC check string
    blk[0] = "1"; blk[1] = "2"; blk[2] = "3"; blk[3] = "4"; blk[4] = "5";
    blk[5] = "6"; blk[6] = "7"; blk[7] = "8"; blk[8] = "9";
    run_block(9, 1'b0, 0, 0, CRC_ON ? 16'h31C3 : 16'h0000);

    // Reset during FILL, then restart from address 0
    for (int i = 0; i < 512; i++) blk[i] = 8'(255 - i);
    run_block(512, 1'b0, 2, 10, 16'h0);
    for (int i = 0; i < 8; i++) blk[i] = 8'h11 * 8'(i + 1);
    run_block(8, 1'b0, 0, 0, CRC_ON ? crc_model(8) : 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
